// File: rtl/s_muxnxw_reg.sv
// -----------------------------------------------------------------------------
// s_muxnxw_reg
//
// Registered N-input, W-bit multiplexer with a held channel register,
// auto-scan mode and a sticky out-of-range select error.
//
// Parameters
//   W   data width of each input lane and of Q (W >= 1)
//   N   number of input lanes (N >= 2)
//   SW  width of SEL and CH, derived as $clog2(N) (not overridden)
//
// Ports
//   CLK   in   1    rising-edge clock
//   RSTB  in   1    asynchronous, active-low reset
//   IN    in   N*W  packed lanes; lane i = IN[i*W +: W]
//   SEL   in   SW   channel to load
//   LD    in   1    load SEL into the channel register (wins over SCAN)
//   SCAN  in   1    advance the channel by one on each enabled cycle
//   EN    in   1    output update / scan-step enable
//   Q     out  W    registered selected lane
//   QV    out  1    Q holds valid data
//   CH    out  SW   current channel register
//   ERR   out  1    sticky: an out-of-range SEL was loaded
//
// Build option
//   MUXR_SETTLE_EN  when defined, every channel change is followed by a
//                   settle slot: the first EN capture after the change is
//                   discarded (Q holds, QV drops to 0). Scan steps pause
//                   during the settle slot, so each lane is presented on
//                   one enabled cycle out of two.
// -----------------------------------------------------------------------------
module s_muxnxw_reg #(
    parameter  int W  = 1,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RSTB,
    input  logic [N*W-1:0] IN,
    input  logic [SW-1:0]  SEL,
    input  logic           LD,
    input  logic           SCAN,
    input  logic           EN,
    output logic [W-1:0]   Q,
    output logic           QV,
    output logic [SW-1:0]  CH,
    output logic           ERR
);

    // Lane count widened by one bit so it can be compared against any SEL code.
    localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
    localparam logic [SW-1:0] CH_LAST = SW'(N-1);

    logic [SW-1:0] r_ch;
    logic [W-1:0]  r_q;
    logic          r_qv;
    logic          r_err;

    logic [W-1:0]  w_lane;
    logic          w_sel_ok;
    logic [SW-1:0] w_ch_inc;
    logic [SW-1:0] w_ch_nxt;
    logic          w_err_set;
    logic          w_step_ok;

`ifdef MUXR_SETTLE_EN
    logic          r_settle;
    // Scan holds its lane through the settle slot so every lane gets one
    // valid capture.
    assign w_step_ok = ~r_settle;
`else
    assign w_step_ok = 1'b1;
`endif

    // r_ch never holds an out-of-range value, so a decoded compare per lane
    // is enough; codes >= N simply match no lane.
    always_comb begin
        // NOTE: every signal driven here gets a default first, otherwise the
        // paths that do not assign it would infer a latch.
        w_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ch == SW'(i)) begin
                w_lane = IN[i*W +: W];
            end
        end
    end

    assign w_sel_ok = ({1'b0, SEL} < N_EXT);
    assign w_ch_inc = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;

    // Channel update priority: valid load, rejected load, scan step, hold.
    always_comb begin
        w_ch_nxt  = r_ch;
        w_err_set = 1'b0;
        if (LD) begin
            if (w_sel_ok) begin
                w_ch_nxt = SEL;
            end else begin
                w_err_set = 1'b1;
            end
        end else if (SCAN && EN && w_step_ok) begin
            w_ch_nxt = w_ch_inc;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; Q therefore picks the lane named by the old CH.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_ch     <= '0;
            r_q      <= '0;
            r_qv     <= 1'b0;
            r_err    <= 1'b0;
`ifdef MUXR_SETTLE_EN
            r_settle <= 1'b0;
`endif
        end else begin
            r_ch <= w_ch_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
`ifdef MUXR_SETTLE_EN
            if (EN) begin
                if (r_settle) begin
                    r_qv <= 1'b0;
                end else begin
                    r_q  <= w_lane;
                    r_qv <= 1'b1;
                end
            end
            // A fresh channel change re-arms the settle slot even if this
            // edge consumed the previous one.
            if (w_ch_nxt != r_ch) begin
                r_settle <= 1'b1;
            end else if (EN) begin
                r_settle <= 1'b0;
            end
`else
            if (EN) begin
                r_q  <= w_lane;
                r_qv <= 1'b1;
            end
`endif
        end
    end

    assign Q   = r_q;
    assign QV  = r_qv;
    assign CH  = r_ch;
    assign ERR = r_err;

endmodule
